// File: rtl/divider_pkg.sv
// Shared definitions for the divider family and mult_acc_seq: default operand
// width and the IDLE/RUN/DONE state encoding.
package divider_pkg;
  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_step.sv
// One combinational add-and-shift step of the sequential multiply-accumulate:
// conditionally add the shifted multiplicand, then shift both operands.
module mult_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier
);
  always_comb begin
    o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
  end
endmodule

// File: rtl/mult_acc_seq.sv
// Sequential shift-and-add multiply-accumulate: dividend = divisor*quotient + remainder.
// Define EARLY_TERM_EN to leave RUN as soon as the remaining multiplier is zero.
module mult_acc_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     remainder,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dividend
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic               w_accept;
  logic               w_last;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mcand  (w_mcand_nxt),
    .o_mplier (w_mplier_nxt)
  );

  assign w_accept = start && (r_state != ST_RUN);

`ifdef EARLY_TERM_EN
  // Nothing left to add once the shifted multiplier is empty.
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state != ST_RUN);
    done  = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      dividend <= '0;
    end else if (w_accept) begin
      r_acc    <= {{WIDTH{1'b0}}, remainder};
      r_mcand  <= {{WIDTH{1'b0}}, divisor};
      r_mplier <= quotient;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt + CW'(1);
      // Result only moves on entry to DONE and then holds.
      if (w_last) dividend <= w_acc_nxt;
    end
  end
endmodule

// File: tb/tb_mult_acc_seq.sv
// Randomized self-checking bench for mult_acc_seq against a plain-arithmetic model.
// Expected RUN length follows EARLY_TERM_EN when it is defined.
module tb_mult_acc_seq;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   divisor, quotient, remainder;
  logic           ready, done;
  logic [2*W-1:0] dividend;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int t_acc = 0;

  mult_acc_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .done      (done),
    .dividend  (dividend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + 64'(c);
    return p & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Cycles from the start cycle to the done cycle.
  function automatic int exp_cycles(input logic [W-1:0] q);
    int r;
    r = W;
`ifdef EARLY_TERM_EN
    r = 1;
    for (int i = 0; i < W; i++) if (q[i]) r = i + 1;
`endif
    return r + 1;
  endfunction

  // Called with clk low; start is sampled at the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    divisor = a; quotient = b; remainder = c; start = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc_cnt;
    start = 1'b0;
    divisor = W'($urandom); quotient = W'($urandom); remainder = W'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = cyc_cnt - t_acc + 1;
        break;
      end
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] c);
    int cycles;
    issue(a, b, c);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(ready), 64'd0);
    wait_done(cycles);
    chk({tag, "_lat"}, 64'(cycles), 64'(exp_cycles(b)));
    chk({tag, "_res"}, 64'(dividend), model(a, b, c));
    chk({tag, "_rdy"}, 64'(ready), 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(dividend), model(a, b, c));
  endtask

  initial begin
    int cycles;
    int n_done;
    logic [W-1:0] a, b, c;
    rst = 1'b1; start = 1'b0; divisor = '0; quotient = '0; remainder = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div", 64'(dividend), 64'd0);

    // rst wins over start
    start = 1'b1; divisor = 16'h0005; quotient = 16'h0005;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("rst_prio_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    op("basic", 16'h0007, 16'h0003, 16'h0002);
    op("allones", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    op("roundtrip", 16'd7, 16'd142, 16'd6);
    op("q_one", 16'h1234, 16'h0001, 16'h0000);
    op("q_zero", 16'h5678, 16'h0000, 16'h1234);

    // start during RUN is ignored
    issue(16'h0123, 16'h8005, 16'h0042);
    repeat (2) @(posedge clk);
    #1; start = 1'b1; divisor = 16'hAAAA; quotient = 16'h5555; remainder = 16'h1111;
    @(negedge clk);
    chk("ign_ready", 64'(ready), 64'd0);
    @(posedge clk); #1; start = 1'b0;
    wait_done(cycles);
    chk("ign_lat", 64'(cycles), 64'(exp_cycles(16'h8005)));
    chk("ign_res", 64'(dividend), model(16'h0123, 16'h8005, 16'h0042));
    @(negedge clk);

    // reset at RUN cycle 5 aborts
    issue(16'h0F0F, 16'h8001, 16'h0003);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_div", 64'(dividend), 64'd0);
    n_done = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    chk("abort_nodone", 64'(n_done), 64'd0);

    // start held through DONE gives back-to-back operation
    issue(16'h0009, 16'h000B, 16'h0001);
    start = 1'b1; divisor = 16'h0002; quotient = 16'h0004; remainder = 16'h0000;
    wait_done(cycles);
    chk("b2b1_lat", 64'(cycles), 64'(exp_cycles(16'h000B)));
    chk("b2b1_res", 64'(dividend), model(16'h0009, 16'h000B, 16'h0001));
    @(posedge clk); #1;
    t_acc = cyc_cnt;
    start = 1'b0;
    wait_done(cycles);
    chk("b2b2_lat", 64'(cycles), 64'(exp_cycles(16'h0004)));
    chk("b2b2_res", 64'(dividend), 64'h0000_0008);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      if (i % 4 == 1) b = b >> $urandom_range(W - 1, 8);
      op("rand", a, b, c);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult_acc_seq.md
MULT_ACC_SEQ -- requirements
Module: mult_acc_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request a new operation.
REQ-005 The block SHALL have port divisor, input, WIDTH, multiplicand.
REQ-006 The block SHALL have port quotient, input, WIDTH, multiplier.
REQ-007 The block SHALL have port remainder, input, WIDTH, addend.
REQ-008 The block SHALL have port ready, output, 1, high when start will be accepted.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking product valid.
REQ-010 The block SHALL have port dividend, output, 2*WIDTH, result divisor*quotient+remainder.

Function
REQ-011 The block SHALL compute unsigned dividend = divisor*quotient + remainder; the result never overflows 2*WIDTH bits.
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, ready SHALL be 1; start=1 SHALL register all three operands, load the accumulator with zero-extended remainder, clear the step counter, and enter RUN.
REQ-014 In RUN, ready SHALL be 0 and start SHALL be ignored.
REQ-015 Each RUN cycle SHALL add the shifted multiplicand (2*WIDTH wide) to the accumulator when the multiplier LSB is 1, then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; with start sampled at edge t, done SHALL be 1 during cycle t+WIDTH+1 only.
REQ-017 In DONE without start, the next state SHALL be IDLE; in DONE with start, the next state SHALL be RUN, giving back-to-back operation with no gap.
REQ-018 The dividend output SHALL be updated only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-019 Operand inputs SHALL be don't-care except in the cycle start is accepted.

Reset
REQ-020 When rst=1 at an edge, the FSM SHALL go to IDLE, set dividend=0, done=0, ready=1 and clear the counter, irrespective of the current state.
REQ-021 rst SHALL take priority over start in the same cycle.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-023 With EARLY_TERM_EN defined, RUN SHALL exit to DONE after the cycle in which the remaining shifted multiplier becomes zero, so RUN lasts max(1, index of the highest set bit of quotient + 1) cycles.
REQ-024 Without EARLY_TERM_EN, RUN SHALL last exactly WIDTH cycles.
REQ-025 The result SHALL be identical with and without EARLY_TERM_EN.

Structure
REQ-026 WIDTH default and the state enum SHALL live in shared package divider_pkg, also used by the divider blocks.
REQ-027 One add-and-shift step SHALL be a sub-module mult_step, which is combinational and instantiated once.
REQ-028 All other logic, including the FSM, counter and registers, SHALL be in mult_acc_seq.

Verification
REQ-029 The bench SHALL check: divisor=0x0007, quotient=0x0003, remainder=0x0002 -> dividend=0x00000017, with done 17 cycles after start (no macro).
REQ-030 The bench SHALL check: divisor=0xFFFF, quotient=0xFFFF, remainder=0xFFFF -> dividend=0xFFFF0000.
REQ-031 The bench SHALL check the divider round trip: divisor=7, quotient=142, remainder=6 -> dividend=0x000003E8 (1000).
REQ-032 The bench SHALL check: start pulsed at RUN cycle 3 -> ignored and result unchanged; rst at RUN cycle 5 -> next cycle ready=1, dividend=0, and no done pulse.
REQ-033 The bench SHALL check: start held high through DONE -> a second operation (0x0002*0x0004+0 = 0x00000008) completes with done 17 cycles after the first done.
REQ-034 The bench SHALL check, with EARLY_TERM_EN: quotient=0x0001 -> done 2 cycles after start; quotient=0x0000, remainder=0x1234 -> dividend=0x00001234 with done 2 cycles after start.
